// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first,
// with a single full-subtractor cell and a borrow flip-flop.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand bit processed per clock, LSB first
// DONE  | one-cycle done pulse, results just registered
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;
  logic             a_msb;
  logic             b_msb;
  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;
  logic             accept;

  // Full-subtractor cell on the current LSBs plus the stored borrow.
  assign bit_d    = op_a[0] ^ op_b[0] ^ borrow_ff;
  assign bit_bout = (~op_a[0] & op_b[0]) | (~op_a[0] & borrow_ff) | (op_b[0] & borrow_ff);
  assign res_next = {bit_d, res[WIDTH-1:1]};
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE accepts start directly for back-to-back operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a       <= '0;
      op_b       <= '0;
      res        <= '0;
      cnt        <= '0;
      borrow_ff  <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      op_a      <= a;
      op_b      <= b;
      res       <= '0;
      cnt       <= '0;
      borrow_ff <= 1'b0;
      a_msb     <= a[WIDTH-1];
      b_msb     <= b[WIDTH-1];
    end else if (state == RUN) begin
      op_a      <= op_a >> 1;
      op_b      <= op_b >> 1;
      res       <= res_next;
      borrow_ff <= bit_bout;
      cnt       <= cnt + CW'(1);
      if (last_bit) begin
        // Overflow uses the captured operand signs; operand regs are shifted out by now.
        diff       <= res_next;
        borrow_out <= bit_bout;
        ovf        <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
        zero       <= (res_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;
  logic       zero;

  int tests  = 0;
  int failed = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .borrow_out(borrow_out),
    .ovf(ovf),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for done; returns edges waited and busy cycles seen.
  task automatic wait_done(output int edges, inout int busy_cnt);
    edges = 0;
    while (!done && edges < 30) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
  endtask

  // Full operation from IDLE: start, wait, check results and single done pulse.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo, input logic ez);
    int edges;
    int busy_cnt;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_on"}, busy, 1);
    check({tag, "_hold"}, diff, prev_diff);
    busy_cnt = 1;
    a = ~av; b = ~bv;
    wait_done(edges, busy_cnt);
    check({tag, "_latency"}, edges, 8);
    check({tag, "_busy_cycles"}, busy_cnt, 8);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow_out, eb);
    check({tag, "_ovf"}, ovf, eo);
    check({tag, "_zero"}, zero, ez);
    prev_diff = ed;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int edges;
    int busy_cnt;
    int done_seen;

    // Reset state
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 8'h00);
    check("rst_flags", {borrow_out, ovf, zero}, 3'b000);
    @(negedge clk);
    rst = 1'b0;

    // Basic and signed/unsigned boundary cases
    run_op("t1", 8'h5A, 8'h1F, 8'h3B, 1'b0, 1'b0, 1'b0);
    run_op("t2a", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0);
    run_op("t2b", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    run_op("t2c", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    run_op("t3a", 8'h33, 8'h33, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op("t3b", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    run_op("t3c", 8'hC4, 8'h00, 8'hC4, 1'b0, 1'b0, 1'b0);

    // Start during RUN is ignored; back-to-back start during DONE
    @(negedge clk);
    a = 8'h5A; b = 8'h1F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_busy_mid", busy, 1);
    busy_cnt = 0;
    wait_done(edges, busy_cnt);
    check("t4_latency", edges, 5);
    check("t4_diff", diff, 8'h3B);
    check("t4_borrow", borrow_out, 0);
    a = 8'h09; b = 8'h04; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("t4_b2b_busy", busy, 1);
    check("t4_b2b_done_low", done, 0);
    check("t4_b2b_hold", diff, 8'h3B);
    busy_cnt = 0;
    wait_done(edges, busy_cnt);
    check("t4_b2b_latency", edges + 1, 9);
    check("t4_b2b_diff", diff, 8'h05);
    check("t4_b2b_flags", {borrow_out, ovf, zero}, 3'b000);
    @(posedge clk); #1;
    check("t4_b2b_pulse", done, 0);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    a = 8'h5A; b = 8'h1F; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_diff", diff, 8'h00);
    check("t5_flags", {borrow_out, ovf, zero}, 3'b000);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("t5_no_done", done_seen, 0);
    prev_diff = 8'h00;
    run_op("t5_new", 8'h02, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

    // Idle with operands changing and start low
    @(negedge clk);
    a = 8'h11; b = 8'h22;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("t6_quiet", done_seen, 0);
    check("t6_diff", diff, 8'h01);
    check("t6_flags", {borrow_out, ovf, zero}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
